// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, fill level and sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_param #(
  parameter int tamano_datos    = 10,
  parameter int tamano_direcion = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [tamano_datos-1:0]    data_in,
  input  logic                       read_enable,
  input  logic [tamano_direcion:0]   af_threshold,
  input  logic [tamano_direcion:0]   ae_threshold,
  output logic [tamano_datos-1:0]    data_out,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [tamano_direcion:0]   count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       error,
  output logic [tamano_direcion-1:0] wr_ptr,
  output logic [tamano_direcion-1:0] rd_ptr
);

  localparam int DEPTH = 1 << tamano_direcion;
  localparam int CW    = tamano_direcion + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [tamano_datos-1:0]    mem_q [DEPTH];
  logic [tamano_direcion-1:0] wr_ptr_q, wr_ptr_d;
  logic [tamano_direcion-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;
  logic                       wr_acc, rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_threshold);
  assign almost_empty = (count_q <= ae_threshold);

  // A write into a full FIFO is still taken when a read frees the slot in the same edge.
  assign rd_acc = read_enable & ~empty;
  assign wr_acc = write_enable & (~full | read_enable);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    overflow_d  = overflow_q | (write_enable & ~wr_acc);
    underflow_d = underflow_q | (read_enable & ~rd_acc);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; writes coinciding with reset are dropped.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out  = mem_q[rd_ptr_q];
  assign valid_out = ~empty;
`else
  logic [tamano_datos-1:0] data_out_q;
  logic                    valid_out_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= rd_acc;
      if (rd_acc) data_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
`endif

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign error     = overflow_q | underflow_q;
  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard plus table-driven bench for fifo_param (10-bit data, depth 8).
// Follows the FIFO_FWFT_EN macro to choose the expected read-path timing.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       writeEnable = 1'b0;
  logic [9:0] dataIn = '0;
  logic       readEnable = 1'b0;
  logic [3:0] afTh = 4'd8;
  logic [3:0] aeTh = 4'd0;
  logic [9:0] dataOut;
  logic       validOut, fullO, emptyO, almostFull, almostEmpty;
  logic [3:0] countO;
  logic       overflowO, underflowO, errorO;
  logic [2:0] wrPtr, rdPtr;

  fifo_param #(.tamano_datos(10), .tamano_direcion(3)) dut (
    .clk(clk), .reset(reset), .write_enable(writeEnable), .data_in(dataIn),
    .read_enable(readEnable), .af_threshold(afTh), .ae_threshold(aeTh),
    .data_out(dataOut), .valid_out(validOut), .full(fullO), .empty(emptyO),
    .almost_full(almostFull), .almost_empty(almostEmpty), .count(countO),
    .overflow(overflowO), .underflow(underflowO), .error(errorO),
    .wr_ptr(wrPtr), .rd_ptr(rdPtr)
  );

  always #5 clk = ~clk;

  int         nCompared = 0;
  int         nFailed = 0;
  int         mCount = 0;
  int         mWr = 0;
  int         mRd = 0;
  logic       mOvf = 1'b0;
  logic       mUnf = 1'b0;
  logic [9:0] mLast = '0;
  logic [9:0] sbQ[$];

  typedef struct {
    logic       we;
    logic [9:0] din;
    logic       re;
    logic [3:0] expCount;
    logic       expAf;
    logic       expAe;
  } vec_t;
  vec_t vecs[11];

  logic [9:0] words[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkFlags();
    checkOutput("count", countO, mCount);
    checkOutput("full", fullO, mCount == 8);
    checkOutput("empty", emptyO, mCount == 0);
    checkOutput("almost_full", almostFull, mCount >= int'(afTh));
    checkOutput("almost_empty", almostEmpty, mCount <= int'(aeTh));
    checkOutput("overflow", overflowO, mOvf);
    checkOutput("underflow", underflowO, mUnf);
    checkOutput("error", errorO, mOvf | mUnf);
    checkOutput("wr_ptr", wrPtr, mWr % 8);
    checkOutput("rd_ptr", rdPtr, mRd % 8);
`ifdef FIFO_FWFT_EN
    checkOutput("fwft_valid", validOut, mCount != 0);
    if (mCount != 0) checkOutput("fwft_data", dataOut, sbQ[0]);
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its own pre-edge state.
  task automatic applyStimulus(input logic we, input logic [9:0] din, input logic re);
    logic       wrAcc, rdAcc;
    logic [9:0] expData;
    rdAcc = re && (mCount != 0);
    wrAcc = we && ((mCount != 8) || re);
    writeEnable = we;
    dataIn      = din;
    readEnable  = re;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    if (we && !wrAcc) mOvf = 1'b1;
    if (re && !rdAcc) mUnf = 1'b1;
    expData = mLast;
    if (rdAcc) begin
      expData = sbQ.pop_front();
      mRd++;
    end
    if (wrAcc) begin
      sbQ.push_back(din);
      mWr++;
    end
    mCount = mCount + int'(wrAcc) - int'(rdAcc);
`ifndef FIFO_FWFT_EN
    checkOutput("valid_out", validOut, rdAcc);
    if (rdAcc) begin
      checkOutput("data_out", dataOut, expData);
      mLast = expData;
    end else begin
      checkOutput("data_out_hold", dataOut, mLast);
    end
`endif
    checkFlags();
  endtask

  task automatic doReset(input int n, input logic we, input logic re);
    reset       = 1'b0;
    writeEnable = we;
    readEnable  = re;
    dataIn      = 10'h3FF;
    repeat (n) @(posedge clk);
    #1;
    mCount = 0; mWr = 0; mRd = 0; mOvf = 1'b0; mUnf = 1'b0; mLast = '0;
    sbQ.delete();
    checkFlags();
`ifndef FIFO_FWFT_EN
    checkOutput("reset_data_out", dataOut, 0);
    checkOutput("reset_valid_out", validOut, 0);
`endif
    reset       = 1'b1;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
  endtask

  initial begin
    words = '{10'h091, 10'h04A, 10'h093, 10'h046, 10'h0B5, 10'h164, 10'h1E5, 10'h266};
    vecs[0]  = '{1'b1, 10'h011, 1'b0, 4'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 10'h022, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10'h033, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10'h044, 1'b0, 4'd4, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 10'h055, 1'b0, 4'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 10'h066, 1'b0, 4'd6, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 10'h000, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 10'h000, 1'b1, 4'd4, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 10'h000, 1'b1, 4'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 10'h000, 1'b1, 4'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 10'h000, 1'b1, 4'd1, 1'b0, 1'b1};

    $display("[TB] reset for 3 cycles");
    doReset(3, 1'b0, 1'b0);

    $display("[TB] fill to full, then overflow");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, words[i], 1'b0);
    checkOutput("full_after_8", fullO, 1);
    checkOutput("count_after_8", countO, 8);
    checkOutput("wr_ptr_wrapped", wrPtr, 0);
    applyStimulus(1'b1, 10'h3AA, 1'b0);
    checkOutput("overflow_9th", overflowO, 1);
    checkOutput("error_9th", errorO, 1);
    checkOutput("count_9th", countO, 8);

    $display("[TB] drain in order, then underflow");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 10'h000, 1'b1);
    checkOutput("empty_after_drain", emptyO, 1);
    applyStimulus(1'b0, 10'h000, 1'b1);
    checkOutput("underflow_9th", underflowO, 1);

    afTh = 4'd0;
    #1;
    checkOutput("af_zero_threshold", almostFull, 1);

    $display("[TB] threshold vectors");
    doReset(1, 1'b0, 1'b0);
    afTh = 4'd6;
    aeTh = 4'd1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, vecs[i].din, vecs[i].re);
      checkOutput("vec_count", countO, vecs[i].expCount);
      checkOutput("vec_almost_full", almostFull, vecs[i].expAf);
      checkOutput("vec_almost_empty", almostEmpty, vecs[i].expAe);
    end

    $display("[TB] simultaneous access at full and empty");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 10'h100 + 10'(i), 1'b0);
    checkOutput("full_before_simul", fullO, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10'h200 + 10'(i), 1'b1);
    checkOutput("count_simul_full", countO, 8);
    checkOutput("no_overflow_simul", overflowO, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 10'h000, 1'b1);
    applyStimulus(1'b1, 10'h155, 1'b1);
    checkOutput("count_simul_empty", countO, 1);
    checkOutput("underflow_simul_empty", underflowO, 1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10'h0F0 + 10'(i), 1'b0);
    checkOutput("count_before_reset", countO, 5);
    doReset(1, 1'b1, 1'b1);
    checkOutput("count_after_reset", countO, 0);
    checkOutput("empty_after_reset", emptyO, 1);
    checkOutput("error_after_reset", errorO, 0);

    applyStimulus(1'b1, 10'h091, 1'b0);
    applyStimulus(1'b1, 10'h04A, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1);
    applyStimulus(1'b0, 10'h000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
